// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one single-cycle-latency memory.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_starve;
    logic               w_idle;
    logic               w_fetch_prio;
    logic               w_grant_if;
    logic               w_grant_d;

    // Gating with reset_n keeps every output low while reset is held, even with requests pending.
    assign w_idle       = (r_state == IDLE) && reset_n;
    assign w_fetch_prio = (r_starve == CNT_W'(STARVE_LIMIT));
    assign w_grant_d    = w_idle && d_req && !(if_req && w_fetch_prio);
    assign w_grant_if   = w_idle && if_req && !w_grant_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Busy states always last one cycle: the memory answers exactly one cycle after mem_en.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: begin
                if (w_grant_if) begin
                    w_next = BUSY_IF;
                end else if (w_grant_d) begin
                    w_next = BUSY_D;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        if (w_grant_if) begin
            if_ready = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_grant_d) begin
            d_ready   = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we ? d_wstrb : STRB_W'(0);
        end

        case (r_state)
            BUSY_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            BUSY_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

    // Counts data grants that bypass a waiting fetch; any cycle without a fetch request clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (w_grant_if || !if_req) begin
            r_starve <= '0;
        end else if (w_grant_d && !w_fetch_prio) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized requesters, all checked
// cycle by cycle against a behavioural model of the grant, priority and response rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: which response is owed next cycle (0 none, 1 fetch, 2 data) and data grants
    // given while a fetch has been waiting.
    int unsigned m_owed = 0;
    int unsigned m_cnt  = 0;

    // Last values observed by step()
    logic          o_if_ready, o_d_ready, o_if_rvalid, o_d_rvalid;
    logic [3:0]    o_mem_we;
    logic [DW-1:0] o_mem_wdata, o_if_rdata, o_d_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs set: checks this cycle, then advances the model.
    task automatic step(input logic [DW-1:0] rd);
        logic exp_d, exp_if;
        logic [3:0] exp_we;
        mem_rdata = rd;
        #2;
        exp_d  = (m_owed == 0) && d_req && !(if_req && (m_cnt == LIMIT));
        exp_if = (m_owed == 0) && if_req && !exp_d;
        exp_we = (exp_d && d_we) ? d_wstrb : 4'h0;
        check_eq("if_ready", 32'(if_ready), 32'(exp_if));
        check_eq("d_ready",  32'(d_ready),  32'(exp_d));
        check_eq("mem_en",   32'(mem_en),   32'(exp_if || exp_d));
        check_eq("mem_we",   32'(mem_we),   32'(exp_we));
        if (exp_if) check_eq("mem_addr_if", mem_addr, if_addr);
        if (exp_d) begin
            check_eq("mem_addr_d", mem_addr, d_addr);
            check_eq("mem_wdata", mem_wdata, d_wdata);
        end
        check_eq("if_rvalid", 32'(if_rvalid), 32'(m_owed == 1));
        check_eq("d_rvalid",  32'(d_rvalid),  32'(m_owed == 2));
        if (m_owed == 1) check_eq("if_rdata", if_rdata, rd);
        if (m_owed == 2 && m_cnt < 1000) check_eq("d_rdata", d_rdata, rd);
        o_if_ready  = if_ready;
        o_d_ready   = d_ready;
        o_if_rvalid = if_rvalid;
        o_d_rvalid  = d_rvalid;
        o_mem_we    = mem_we;
        o_mem_wdata = mem_wdata;
        o_if_rdata  = if_rdata;
        o_d_rdata   = d_rdata;
        @(posedge clk);
        m_owed = exp_if ? 1 : (exp_d ? 2 : 0);
        if (exp_if || !if_req) m_cnt = 0;
        else if (exp_d && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        int unsigned code, n_grants, bad_gap, cyc, seen;

        reset_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
        mem_rdata = 32'h0;

        // Outputs stay low while reset is held, despite both requests pending
        #3;
        check_eq("rst_if_ready", 32'(if_ready), 32'd0);
        check_eq("rst_d_ready",  32'(d_ready),  32'd0);
        check_eq("rst_mem_en",   32'(mem_en),   32'd0);
        check_eq("rst_mem_we",   32'(mem_we),   32'd0);
        check_eq("rst_rvalid",   32'({if_rvalid, d_rvalid}), 32'd0);

        // Grant in the very first cycle after release
        @(negedge clk);
        reset_n = 1'b1;
        step($urandom());
        check_eq("first_grant_d", 32'(o_d_ready), 32'd1);
        idle_inputs();
        step($urandom());
        step($urandom());

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10;
        step($urandom());
        check_eq("fetch_ready", 32'(o_if_ready), 32'd1);
        idle_inputs();
        step(32'h0050_0393);
        check_eq("fetch_rvalid", 32'(o_if_rvalid), 32'd1);
        check_eq("fetch_rdata", o_if_rdata, 32'h0050_0393);

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        step($urandom());
        check_eq("store_we", 32'(o_mem_we), 32'hF);
        check_eq("store_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        idle_inputs();
        step($urandom());
        check_eq("store_rvalid", 32'(o_d_rvalid), 32'd1);
        check_eq("store_no_if_rvalid", 32'(o_if_rvalid), 32'd0);

        // Load with all strobes set still writes nothing
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204; d_wstrb = 4'hF;
        step($urandom());
        check_eq("load_we", 32'(o_mem_we), 32'h0);
        idle_inputs();
        step(32'hCAFE_F00D);
        check_eq("load_rdata", o_d_rdata, 32'hCAFE_F00D);
        step($urandom());

        // Contention: both held high, record grant order and spacing
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h300; d_addr = 32'h400;
        code = 0; n_grants = 0; bad_gap = 0;
        for (int c = 0; c < 20; c++) begin
            step($urandom());
            if (o_if_ready || o_d_ready) begin
                code = (code << 1) | 32'(o_if_ready);
                if (c != int'(2 * n_grants)) bad_gap++;
                n_grants++;
            end
        end
        check_eq("contention_order", code, 32'h021);
        check_eq("contention_count", n_grants, 32'd10);
        check_eq("contention_gap", bad_gap, 32'd0);

        // Fetch request raised during a data response and withdrawn before it could be granted
        idle_inputs();
        step($urandom());
        step($urandom());
        d_req = 1'b1; d_we = 1'b0;
        step($urandom());
        d_req = 1'b0; if_req = 1'b1;
        step($urandom());
        if_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            step($urandom());
            seen += 32'(o_if_rvalid) + 32'(o_if_ready);
        end
        check_eq("withdrawn_no_fetch", seen, 32'd0);

        // Reset while the data response is pending
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        #2;
        check_eq("pre_rst_d_ready", 32'(d_ready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        d_req = 1'b0;
        #1;
        check_eq("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
        check_eq("midrst_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_owed = 0; m_cnt = 0;
        @(negedge clk);
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            step($urandom());
            seen += 32'(o_d_rvalid);
        end
        check_eq("postrst_no_rvalid", seen, 32'd0);
        d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hA5A5_5A5A; d_wstrb = 4'h3;
        step($urandom());
        check_eq("postrst_grant", 32'(o_d_ready), 32'd1);
        idle_inputs();
        step($urandom());

        // Randomized requesters: hold until accepted, occasionally withdraw
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (!if_req || o_if_ready) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!d_req || o_d_ready) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom();
                d_wdata = $urandom();
                d_wstrb = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            step($urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of all address ports.
REQ-002 Parameter: DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).
REQ-003 Parameter: STARVE_LIMIT, 4, max consecutive data grants while a fetch waits.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch request; held until if_ready.
REQ-007 if_addr  input  ADDR_WIDTH  fetch address.
REQ-008 if_ready  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  if_rdata valid this cycle.
REQ-010 if_rdata  output  32  fetched word.
REQ-011 d_req  input  1  load/store request; held until d_ready.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_WIDTH  data address.
REQ-014 d_wdata  input  32  store data.
REQ-015 d_wstrb  input  4  store byte enables.
REQ-016 d_ready  output  1  data request accepted this cycle.
REQ-017 d_rvalid  output  1  load data valid or store complete this cycle.
REQ-018 d_rdata  output  32  loaded word.
REQ-019 mem_en  output  1  memory access strobe.
REQ-020 mem_we  output  4  memory byte write enables.
REQ-021 mem_addr  output  ADDR_WIDTH  memory address.
REQ-022 mem_wdata  output  32  memory write data.
REQ-023 mem_rdata  input  32  memory read data, valid exactly 1 cycle after mem_en.

Function
REQ-024 FSM states: IDLE, BUSY_IF, BUSY_D; one transaction outstanding at most.
REQ-025 IDLE: grant evaluated combinationally; granted requester's ready, mem_en and mem_addr asserted same cycle; next state BUSY_IF or BUSY_D.
REQ-026 Priority: d_req wins over if_req, except fetch wins when starvation counter == STARVE_LIMIT.
REQ-027 Starvation counter: +1 per data grant while if_req high; cleared on fetch grant or when if_req low; saturates at STARVE_LIMIT.
REQ-028 Data grant: mem_we = d_wstrb if d_we else 4'b0; mem_wdata = d_wdata; fetch grant: mem_we = 0.
REQ-029 BUSY_IF: if_rvalid = 1, if_rdata = mem_rdata; BUSY_D: d_rvalid = 1, d_rdata = mem_rdata (don't-care for stores); both return to IDLE next cycle.
REQ-030 No grant in BUSY states; ready outputs 0; max throughput one access per 2 cycles.
REQ-031 Simultaneous if_req and d_req below limit: data granted, fetch waits (if_ready = 0).
REQ-032 Request deasserted before grant: no access issued, no rvalid.
REQ-033 mem_en, mem_we, ready outputs 0 whenever no grant occurs; mem_addr/mem_wdata don't-care then.
REQ-034 rvalid pulses exactly one cycle per accepted request, never to the non-granted requester.

Reset
REQ-035 reset_n low: state IDLE, counter 0, all outputs 0 immediately (asynchronous).
REQ-036 Reset mid-transaction (BUSY_*): pending rvalid dropped, no response after release.
REQ-037 First grant possible in the first cycle reset_n is high.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0x00500393 -> cycle 0 if_ready=1, mem_en=1, mem_addr=0x10, mem_we=0; cycle 1 if_rvalid=1, if_rdata=0x00500393.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_we=0xF, mem_wdata=0xDEADBEEF same cycle; d_rvalid=1 next cycle; if_rvalid stays 0.
REQ-040 Contention: if_req and d_req held high continuously -> grant order D,D,D,D,IF,D,D,D,D,IF (STARVE_LIMIT=4), each grant 2 cycles apart.
REQ-041 Load byte-strobe: d_we=0, d_wstrb=0xF -> mem_we=0, d_rdata = mem_rdata returned 1 cycle later.
REQ-042 Reset in BUSY_D: assert reset_n=0 for 1 cycle after d_ready -> d_rvalid never asserts; next request granted normally.
REQ-043 Withdrawn request: if_req high one cycle during BUSY_D then low -> no fetch access, if_rvalid never asserts.
